// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds default geometry, the PC increment and the fetch-entry bundle type.
package fetch_pkg;

    localparam int PC_W_DEF       = 16;
    localparam int INSTR_W_DEF    = 16;
    localparam int MEM_LAT_DEF    = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int PC_STEP        = 2;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with synchronous flush and count output.
// Ports: clk/rst (async high), flush, push/push_data, pop, out_valid/out_data (head), count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        // A full buffer can still accept when the head leaves this cycle.
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = nxt(wr_q);
            end
            if (do_pop) begin
                rd_d = nxt(rd_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_q];
    assign count     = cnt_q;

endmodule

// File: rtl/fetch_pipeline.sv
// Instruction-fetch front end: PC, fixed-latency memory tracking, buffered valid/ready output.
// Ports: clk/rst, halt, redirect/redirect_pc, mem_raddr/mem_rdata, out_valid/out_ready/
// out_instr/out_pc, perf_stall_cnt/perf_flush_cnt (live only with FETCH_PERF_EN defined).
module fetch_pipeline
    import fetch_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              INSTR_W    = INSTR_W_DEF,
    parameter int              MEM_LAT    = MEM_LAT_DEF,
    parameter int              FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-2:0]    mem_raddr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + MEM_LAT + 1);
    localparam int EW  = PC_W + INSTR_W;

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("fetch_pipeline: MEM_LAT must be >= 1");
    end
    if (FIFO_DEPTH < MEM_LAT + 2) begin : g_bad_depth
        $error("fetch_pipeline: FIFO_DEPTH must be >= MEM_LAT+2");
    end
    if (RESET_PC[0]) begin : g_bad_rpc
        $error("fetch_pipeline: RESET_PC must be even");
    end

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [PC_W-1:0]    ipc_q [MEM_LAT];
    logic [PC_W-1:0]    ipc_d [MEM_LAT];
    logic [SW-1:0]      inflight;
    logic               issue;
    logic               push;
    logic               pop;
    logic [EW-1:0]      push_data;
    logic [EW-1:0]      head;
    logic [FCW-1:0]     fifo_count;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + SW'(vld_q[i]);
        end
        // Credits ignore a same-cycle pop, so the buffer can never overflow.
        issue = !halt && !redirect &&
                ((inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH));

        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~PC_W'(1);
        end else if (issue) begin
            pc_d = pc_q + PC_W'(PC_STEP);
        end

        ipc_d    = ipc_q;
        vld_d    = '0;
        vld_d[0] = issue;
        ipc_d[0] = pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            ipc_d[i] = ipc_q[i-1];
        end
        if (redirect) begin
            vld_d = '0;
        end

        // Oldest stage lines up with the data arriving this cycle.
        push      = vld_q[MEM_LAT-1] && !redirect;
        push_data = {ipc_q[MEM_LAT-1], mem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            vld_q <= '0;
            ipc_q <= '{default: '0};
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
            ipc_q <= ipc_d;
        end
    end

    assign mem_raddr = pc_q[PC_W-1:1];
    assign pop       = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (head),
        .count     (fifo_count)
    );

    assign out_pc    = head[EW-1:INSTR_W];
    assign out_instr = head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;
    logic [32:0] flush_sum;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        // Discarded work: every valid in-flight stage plus every buffered entry.
        flush_sum = {1'b0, flush_q} + 33'(inflight) + 33'(fifo_count);
        flush_d   = flush_q;
        if (redirect) begin
            flush_d = flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pipeline.sv
// Self-checking bench for fetch_pipeline: directed scenarios plus random traffic.
// Reference model tracks the next expected PC of the in-order fetch stream.
module tb_fetch_pipeline;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect;
    logic        out_ready;
    logic [15:0] redirect_pc;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    logic [14:0] w_raddr;
    logic [15:0] w_rdata;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [15:0] w_pc;
    logic [31:0] w_ps;
    logic [31:0] w_pf;

    logic [14:0] hist   [ML];
    logic [14:0] w_hist [ML];

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          acc_before;
    logic [15:0] exp_pc;
    logic [15:0] w_exp;
    bit          prev_stall;
    logic [15:0] prev_pc;
    logic [15:0] prev_instr;

    always #5 clk = ~clk;

    fetch_pipeline #(
        .PC_W(16), .INSTR_W(16), .MEM_LAT(ML), .FIFO_DEPTH(4),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    fetch_pipeline #(
        .PC_W(16), .INSTR_W(16), .MEM_LAT(ML), .FIFO_DEPTH(4),
        .RESET_PC(16'hFFFC)
    ) dut_wrap (
        .clk(clk), .rst(rst), .halt(1'b0), .redirect(1'b0),
        .redirect_pc(16'h0000), .mem_raddr(w_raddr),
        .mem_rdata(w_rdata), .out_valid(w_valid),
        .out_ready(1'b1), .out_instr(w_instr), .out_pc(w_pc),
        .perf_stall_cnt(w_ps), .perf_flush_cnt(w_pf)
    );

    function automatic logic [15:0] f(input logic [15:0] pc);
        return pc ^ 16'hA5A5;
    endfunction

    // Fixed-latency instruction memory: data for an address appears ML cycles later.
    always @(posedge clk) begin
        hist[0]   <= mem_raddr;
        w_hist[0] <= w_raddr;
        for (int i = 1; i < ML; i++) begin
            hist[i]   <= hist[i-1];
            w_hist[i] <= w_hist[i-1];
        end
    end
    assign mem_rdata = f({hist[ML-1], 1'b0});
    assign w_rdata   = f({w_hist[ML-1], 1'b0});

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        if (rst) return;
        if (prev_stall) begin
            check("hold_pc", 32'(out_pc), 32'(prev_pc));
            check("hold_instr", 32'(out_instr), 32'(prev_instr));
        end
        if (out_valid && out_ready) begin
            check("seq_pc", 32'(out_pc), 32'(exp_pc));
            check("seq_instr", 32'(out_instr), 32'(f(exp_pc)));
            exp_pc = exp_pc + 16'd2;
            accepted++;
        end
        prev_stall = out_valid && !out_ready && !redirect;
        prev_pc    = out_pc;
        prev_instr = out_instr;
        if (redirect) exp_pc = redirect_pc & 16'hFFFE;
        if (w_valid) begin
            check("wrap_pc", 32'(w_pc), 32'(w_exp));
            check("wrap_instr", 32'(w_instr), 32'(f(w_exp)));
            w_exp = w_exp + 16'd2;
        end
    endtask

    task automatic step();
        observe();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        halt      = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        cyc        = 0;
        exp_pc     = 16'h0000;
        w_exp      = 16'hFFFC;
        prev_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        check("rst_stall_cnt", perf_stall_cnt, 32'd0);
        check("rst_flush_cnt", perf_flush_cnt, 32'd0);
        check("rst_wrap_raddr", 32'(w_raddr), 32'h7FFE);
        check("rst_wrap_perf", w_ps | w_pf, 32'd0);

        // Latency from reset and streaming.
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            check("lat_gap", 32'(out_valid), 32'd0);
            step();
        end
        check("lat_first", 32'(out_valid), 32'd1);
        check("lat_pc", 32'(out_pc), 32'h0000);
        check("wrap_first", 32'(w_valid), 32'd1);
        step();
        step();

        // Backpressure for ten cycles with pc 0x0004 at the head.
        check("stall_head", 32'(out_pc), 32'h0004);
        out_ready = 1'b0;
        repeat (9) step();
        check("stall_credit_raddr", 32'(mem_raddr), 32'h0006);
        step();
        out_ready = 1'b1;
`ifdef FETCH_PERF_EN
        check("perf_stall", perf_stall_cnt, 32'd10);
`else
        check("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
        repeat (10) step();

        // Halt first, then redirect with two buffered and two in flight.
        reset_dut();
        halt      = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("halt_noissue", 32'(mem_raddr), 32'd0);
            step();
        end
        halt = 1'b0;
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        step();
        redirect  = 1'b0;
        out_ready = 1'b1;
`ifdef FETCH_PERF_EN
        check("perf_flush", perf_flush_cnt, 32'd4);
`else
        check("perf_flush_off", perf_flush_cnt, 32'd0);
`endif
        for (int c = 0; c < 3; c++) begin
            check("redir_gap", 32'(out_valid), 32'd0);
            step();
        end
        check("redir_valid", 32'(out_valid), 32'd1);
        check("redir_pc", 32'(out_pc), 32'h0040);

        // Halt while streaming: drain, then resume sequentially.
        repeat (11) step();
        halt = 1'b1;
        repeat (4) step();
        check("halt_drain", 32'(out_valid), 32'd0);
        check("halt_next_pc", 32'({mem_raddr, 1'b0}), 32'(exp_pc));
        halt = 1'b0;
        repeat (10) step();

        // Asynchronous reset with the buffer full.
        out_ready = 1'b0;
        repeat (8) step();
        check("full_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc", 32'(out_pc), 32'd0);
        check("arst_instr", 32'(out_instr), 32'd0);
        check("arst_raddr", 32'(mem_raddr), 32'd0);
        @(negedge clk);
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            check("arst_gap", 32'(out_valid), 32'd0);
            step();
        end
        check("arst_first", 32'(out_valid), 32'd1);
        check("arst_pc0", 32'(out_pc), 32'h0000);

        // Random traffic against the stream model.
        acc_before = accepted;
        for (int k = 0; k < 400; k++) begin
            out_ready   = ($urandom_range(9) < 7);
            halt        = ($urandom_range(9) == 0);
            redirect    = ($urandom_range(31) == 0);
            redirect_pc = 16'($urandom);
            step();
        end
        redirect  = 1'b0;
        halt      = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        check("rand_progress", 32'(accepted - acc_before > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
